// File: rtl/capture_pkg.sv
// Shared types for the capture controller: FSM state encoding and trigger edge select.
package capture_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        WAIT_TRIG,
        POST,
        DONE
    } cap_state_t;

    typedef enum logic {
        EDGE_RISE,
        EDGE_FALL
    } trig_edge_t;

    // States in which incoming samples are written to the buffer.
    function automatic logic is_busy(cap_state_t s);
        return (s == PRE) || (s == WAIT_TRIG) || (s == POST);
    endfunction

endpackage

// File: rtl/capture_controller_if.sv
// Bundle of control, sample and buffer-write signals around the capture controller.
// Handshake: sample_data is consumed on every clk edge where sample_valid is high;
// there is no back-pressure. buf_we qualifies buf_waddr/buf_wdata for exactly one
// cycle per written sample, one cycle after the sample was presented.
interface capture_controller_if
    import capture_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              arm;
    logic              force_trig;
    logic              sample_valid;
    logic [DATA_W-1:0] sample_data;
    logic [DATA_W-1:0] trig_level;
    logic              trig_falling;
    logic [ADDR_W-1:0] pre_count;
    logic              buf_we;
    logic [ADDR_W-1:0] buf_waddr;
    logic [DATA_W-1:0] buf_wdata;
    logic [ADDR_W-1:0] trig_addr;
    logic              busy;
    logic              triggered;
    logic              done;
    cap_state_t        state_dbg;

    modport master (
        output arm, force_trig, sample_valid, sample_data, trig_level, trig_falling, pre_count,
        input  buf_we, buf_waddr, buf_wdata, trig_addr, busy, triggered, done, state_dbg
    );

    modport slave (
        input  arm, force_trig, sample_valid, sample_data, trig_level, trig_falling, pre_count,
        output buf_we, buf_waddr, buf_wdata, trig_addr, busy, triggered, done, state_dbg
    );

endinterface

// File: rtl/capture_controller_trig_detect.sv
// Level-crossing detector: remembers the previous valid sample since arm and flags
// a signed crossing of the threshold in the selected direction.
module trig_detect
    import capture_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    input  logic [DATA_W-1:0] level,
    input  trig_edge_t        edge_sel,
    output logic              hit
);

    logic [DATA_W-1:0] prev_q, prev_d;
    logic              prev_valid_q, prev_valid_d;
    logic              cond_rise;
    logic              cond_fall;

    // Next previous-sample value; an arm-cycle sample is the first of the new capture.
    always_comb begin
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        if (clear) begin
            prev_valid_d = 1'b0;
        end
        if (sample_valid) begin
            prev_d       = sample_data;
            prev_valid_d = 1'b1;
        end
    end

    // Signed crossing compare; no hit on the arm cycle since history is stale then.
    always_comb begin
        cond_rise = ($signed(prev_q) < $signed(level)) && ($signed(sample_data) >= $signed(level));
        cond_fall = ($signed(prev_q) > $signed(level)) && ($signed(sample_data) <= $signed(level));
        hit = sample_valid && prev_valid_q && !clear &&
              ((edge_sel == EDGE_FALL) ? cond_fall : cond_rise);
    end

    // Previous-sample register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
        end
    end

endmodule

// File: rtl/capture_controller.sv
// Capture sequencer: arm, pre-trigger fill, wait for trigger, post-trigger fill, done.
// Owns the ring write pointer and drives the capture RAM write port.
module capture_controller
    import capture_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    capture_controller_if.slave  bus
);

    // DEPTH expressed in the post counter's width (one bit wider than an address).
    localparam logic [ADDR_W:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};

    cap_state_t        state_q, state_d;
    logic [DATA_W-1:0] level_q, level_d;
    trig_edge_t        edge_q, edge_d;
    logic [ADDR_W-1:0] pre_q, pre_d;
    logic [ADDR_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [ADDR_W:0]   post_cnt_q, post_cnt_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic              force_q, force_d;
    logic              triggered_q, triggered_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Effective context for this cycle's sample: arm replaces the running capture.
    cap_state_t        cur_state;
    logic [ADDR_W-1:0] cur_pre;
    logic [ADDR_W-1:0] cur_wptr;
    logic [ADDR_W-1:0] cur_pre_cnt;
    logic              cur_force;
    logic [ADDR_W:0]   post_target;
    logic              hit;

    trig_detect #(
        .DATA_W (DATA_W)
    ) u_trig_detect (
        .clk          (clk),
        .rst          (rst),
        .clear        (bus.arm),
        .sample_valid (bus.sample_valid),
        .sample_data  (bus.sample_data),
        .level        (level_q),
        .edge_sel     (edge_q),
        .hit          (hit)
    );

    // Next-state, counters, pointer and write-port decode.
    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        edge_d      = edge_q;
        pre_d       = pre_q;
        pre_cnt_d   = pre_cnt_q;
        post_cnt_d  = post_cnt_q;
        wptr_d      = wptr_q;
        force_d     = force_q;
        triggered_d = triggered_q;
        trig_addr_d = trig_addr_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;

        cur_state   = state_q;
        cur_pre     = pre_q;
        cur_wptr    = wptr_q;
        cur_pre_cnt = pre_cnt_q;
        cur_force   = force_q;

        if (bus.arm) begin
            level_d     = bus.trig_level;
            edge_d      = bus.trig_falling ? EDGE_FALL : EDGE_RISE;
            pre_d       = bus.pre_count;
            cur_state   = (bus.pre_count == '0) ? WAIT_TRIG : PRE;
            cur_pre     = bus.pre_count;
            cur_wptr    = '0;
            cur_pre_cnt = '0;
            cur_force   = 1'b0;
            state_d     = cur_state;
            pre_cnt_d   = '0;
            post_cnt_d  = '0;
            wptr_d      = '0;
            force_d     = 1'b0;
            triggered_d = 1'b0;
        end

        post_target = DEPTH_V - {1'b0, cur_pre};

        if ((cur_state == WAIT_TRIG) && bus.force_trig) begin
            force_d = 1'b1;
        end

        if (bus.sample_valid && is_busy(cur_state)) begin
            we_d    = 1'b1;
            waddr_d = cur_wptr;
            wdata_d = bus.sample_data;
            wptr_d  = cur_wptr + 1'b1;
            unique case (cur_state)
                PRE: begin
                    pre_cnt_d = cur_pre_cnt + 1'b1;
                    if (pre_cnt_d == cur_pre) begin
                        state_d = WAIT_TRIG;
                    end
                end
                WAIT_TRIG: begin
                    if (hit || cur_force || bus.force_trig) begin
                        state_d     = POST;
                        trig_addr_d = cur_wptr;
                        triggered_d = 1'b1;
                        force_d     = 1'b0;
                        post_cnt_d  = {{ADDR_W{1'b0}}, 1'b1};
                        if (post_target == {{ADDR_W{1'b0}}, 1'b1}) begin
                            state_d = DONE;
                        end
                    end
                end
                POST: begin
                    post_cnt_d = post_cnt_q + 1'b1;
                    if (post_cnt_d == post_target) begin
                        state_d = DONE;
                    end
                end
                default: begin
                end
            endcase
        end

        busy_d = is_busy(state_d);
        done_d = (state_d == DONE);
    end

    // State, configuration, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            level_q     <= '0;
            edge_q      <= EDGE_RISE;
            pre_q       <= '0;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
            wptr_q      <= '0;
            force_q     <= 1'b0;
            triggered_q <= 1'b0;
            trig_addr_q <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            edge_q      <= edge_d;
            pre_q       <= pre_d;
            pre_cnt_q   <= pre_cnt_d;
            post_cnt_q  <= post_cnt_d;
            wptr_q      <= wptr_d;
            force_q     <= force_d;
            triggered_q <= triggered_d;
            trig_addr_q <= trig_addr_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.buf_we    = we_q;
    assign bus.buf_waddr = waddr_q;
    assign bus.buf_wdata = wdata_q;
    assign bus.trig_addr = trig_addr_q;
    assign bus.busy      = busy_q;
    assign bus.triggered = triggered_q;
    assign bus.done      = done_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_capture_controller.sv
// Directed bench for capture_controller (DATA_W=16, ADDR_W=8).
module tb_capture_controller;
    import capture_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    logic [7:0]  wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    logic [15:0] mem [256];

    capture_controller_if #(.DATA_W(16), .ADDR_W(8)) bus ();

    capture_controller #(
        .DATA_W (16),
        .ADDR_W (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- write monitor (away from the active edge) ----------------
    always @(negedge clk) begin
        if (bus.buf_we === 1'b1) begin
            wr_addr_q.push_back(bus.buf_waddr);
            wr_data_q.push_back(bus.buf_wdata);
            mem[bus.buf_waddr] = bus.buf_wdata;
        end
    end

    // ---------------- driver tasks ----------------
    // Entered at posedge+1; holds inputs across one rising edge, returns at posedge+1.
    task automatic cyc(input logic v, input logic [15:0] d, input logic a, input logic f);
        bus.sample_valid = v;
        bus.sample_data  = d;
        bus.arm          = a;
        bus.force_trig   = f;
        @(posedge clk);
        #1;
        bus.sample_valid = 1'b0;
        bus.arm          = 1'b0;
        bus.force_trig   = 1'b0;
    endtask

    task automatic do_arm(input logic [7:0] pre, input logic [15:0] lvl, input logic fall);
        bus.pre_count    = pre;
        bus.trig_level   = lvl;
        bus.trig_falling = fall;
        cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.state_dbg !== IDLE || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.triggered !== 1'b0 || bus.buf_we !== 1'b0 || bus.buf_waddr !== 8'd0 ||
            bus.buf_wdata !== 16'd0 || bus.trig_addr !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: state=%0d busy=%b done=%b trig=%b we=%b waddr=%0d wdata=%0h taddr=%0d, expected IDLE and all zero",
                     bus.state_dbg, bus.busy, bus.done, bus.triggered, bus.buf_we,
                     bus.buf_waddr, bus.buf_wdata, bus.trig_addr);
        end
        rst = 1'b0;
        cyc(1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic test_ramp_rising();
        int i;
        clear_log();
        do_arm(8'd64, 16'd0, 1'b0);
        i = 0;
        while (bus.done !== 1'b1 && i < 400) begin
            cyc(1'b1, 16'(i - 100), 1'b0, 1'b0);
            i++;
        end
        n_checks++;
        if (bus.done !== 1'b1 || i != 292) begin
            n_fail++;
            $display("FAIL ramp_done: done=%b after %0d samples, expected done=1 after 292", bus.done, i);
        end
        n_checks++;
        if (bus.busy !== 1'b0 || bus.triggered !== 1'b1 || bus.trig_addr !== 8'd100) begin
            n_fail++;
            $display("FAIL ramp_trigger: busy=%b triggered=%b trig_addr=%0d, expected 0 1 100",
                     bus.busy, bus.triggered, bus.trig_addr);
        end
        cyc(1'b0, 16'h0000, 1'b0, 1'b0);
        n_checks++;
        if (wr_addr_q.size() != 292) begin
            n_fail++;
            $display("FAIL ramp_write_count: got %0d writes, expected 292", wr_addr_q.size());
        end else begin
            n_checks++;
            if (wr_addr_q[100] !== 8'd100 || wr_data_q[100] !== 16'd0 ||
                wr_addr_q[291] !== 8'd35 || wr_data_q[291] !== 16'd191) begin
                n_fail++;
                $display("FAIL ramp_write_seq: trig write %0d/%0h last %0d/%0h, expected 100/0 35/bf",
                         wr_addr_q[100], wr_data_q[100], wr_addr_q[291], wr_data_q[291]);
            end
        end
        n_checks++;
        if (mem[36] !== 16'hffc0) begin
            n_fail++;
            $display("FAIL ramp_history_start: mem[36]=%0h, expected ffc0", mem[36]);
        end
        for (int k = 0; k < 5; k++) cyc(1'b1, 16'(500 + k), 1'b0, 1'b0);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0);
        n_checks++;
        if (wr_addr_q.size() != 292 || bus.done !== 1'b1) begin
            n_fail++;
            $display("FAIL ramp_done_no_write: writes=%0d done=%b, expected 292 1", wr_addr_q.size(), bus.done);
        end
    endtask

    task automatic test_force_pre0();
        int bad;
        clear_log();
        do_arm(8'd0, 16'd0, 1'b0);
        n_checks++;
        if (bus.state_dbg !== WAIT_TRIG || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL force_wait_state: state=%0d busy=%b, expected WAIT_TRIG 1", bus.state_dbg, bus.busy);
        end
        cyc(1'b0, 16'h0000, 1'b0, 1'b1);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 256; i++) begin
            cyc(1'b1, 16'(i * 3), 1'b0, 1'b0);
            if (i == 0) begin
                n_checks++;
                if (bus.triggered !== 1'b1 || bus.trig_addr !== 8'd0) begin
                    n_fail++;
                    $display("FAIL force_trigger: triggered=%b trig_addr=%0d, expected 1 0", bus.triggered, bus.trig_addr);
                end
            end
            if (i == 254) begin
                n_checks++;
                if (bus.done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL force_early_done: done=%b after 255 samples, expected 0", bus.done);
                end
            end
        end
        n_checks++;
        if (bus.done !== 1'b1) begin
            n_fail++;
            $display("FAIL force_done: done=%b after 256 samples, expected 1", bus.done);
        end
        cyc(1'b1, 16'h1234, 1'b0, 1'b0);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0);
        bad = 0;
        for (int i = 0; i < wr_addr_q.size() && i < 256; i++) begin
            if (wr_addr_q[i] !== 8'(i) || wr_data_q[i] !== 16'(i * 3)) bad++;
        end
        n_checks++;
        if (wr_addr_q.size() != 256 || bad != 0) begin
            n_fail++;
            $display("FAIL force_write_seq: writes=%0d bad=%0d, expected 256 0", wr_addr_q.size(), bad);
        end
    endtask

    task automatic test_wrap();
        clear_log();
        do_arm(8'd16, 16'd0, 1'b0);
        for (int i = 0; i < 300; i++) cyc(1'b1, 16'hfffb, 1'b0, 1'b0);
        n_checks++;
        if (bus.triggered !== 1'b0 || bus.state_dbg !== WAIT_TRIG) begin
            n_fail++;
            $display("FAIL wrap_flat: triggered=%b state=%0d, expected 0 WAIT_TRIG", bus.triggered, bus.state_dbg);
        end
        cyc(1'b1, 16'd10, 1'b0, 1'b0);
        n_checks++;
        if (bus.triggered !== 1'b1 || bus.trig_addr !== 8'd44) begin
            n_fail++;
            $display("FAIL wrap_trig_addr: triggered=%b trig_addr=%0d, expected 1 44", bus.triggered, bus.trig_addr);
        end
        for (int i = 0; i < 238; i++) cyc(1'b1, 16'd7, 1'b0, 1'b0);
        n_checks++;
        if (bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_early_done: done=%b after 239 post samples, expected 0", bus.done);
        end
        cyc(1'b1, 16'd7, 1'b0, 1'b0);
        n_checks++;
        if (bus.done !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_done: done=%b after 240 post samples, expected 1", bus.done);
        end
        cyc(1'b0, 16'h0000, 1'b0, 1'b0);
        n_checks++;
        if (wr_addr_q.size() != 540 || mem[44] !== 16'd10 || mem[28] !== 16'hfffb || mem[27] !== 16'd7) begin
            n_fail++;
            $display("FAIL wrap_buffer: writes=%0d mem44=%0h mem28=%0h mem27=%0h, expected 540 a fffb 7",
                     wr_addr_q.size(), mem[44], mem[28], mem[27]);
        end
    endtask

    task automatic test_stall();
        int i;
        int bad;
        clear_log();
        do_arm(8'd64, 16'd0, 1'b0);
        i = 0;
        bad = 0;
        while (bus.done !== 1'b1 && i < 400) begin
            cyc(1'b1, 16'(i - 100), 1'b0, 1'b0);
            if (bus.buf_we !== 1'b1 || bus.buf_waddr !== 8'(i) || bus.buf_wdata !== 16'(i - 100)) bad++;
            cyc(1'b0, 16'h0000, 1'b0, 1'b0);
            if (bus.buf_we !== 1'b0) bad++;
            cyc(1'b0, 16'h0000, 1'b0, 1'b0);
            if (bus.buf_we !== 1'b0) bad++;
            i++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stall_write_timing: %0d bad cycles, expected 0", bad);
        end
        n_checks++;
        if (bus.done !== 1'b1 || i != 292 || bus.trig_addr !== 8'd100 || wr_addr_q.size() != 292) begin
            n_fail++;
            $display("FAIL stall_result: done=%b samples=%0d trig_addr=%0d writes=%0d, expected 1 292 100 292",
                     bus.done, i, bus.trig_addr, wr_addr_q.size());
        end
    endtask

    task automatic test_edge_modes();
        // Falling edge through level 100.
        do_arm(8'd2, 16'd100, 1'b1);
        cyc(1'b1, 16'd200, 1'b0, 1'b0);
        cyc(1'b1, 16'd150, 1'b0, 1'b0);
        cyc(1'b1, 16'd120, 1'b0, 1'b0);
        n_checks++;
        if (bus.triggered !== 1'b0) begin
            n_fail++;
            $display("FAIL fall_early: triggered=%b at 120, expected 0", bus.triggered);
        end
        cyc(1'b1, 16'd100, 1'b0, 1'b0);
        n_checks++;
        if (bus.triggered !== 1'b1 || bus.trig_addr !== 8'd3) begin
            n_fail++;
            $display("FAIL fall_trigger: triggered=%b trig_addr=%0d, expected 1 3", bus.triggered, bus.trig_addr);
        end
        // Rising through a negative level: must compare as signed.
        do_arm(8'd1, 16'hfff6, 1'b0);
        cyc(1'b1, 16'd100, 1'b0, 1'b0);
        cyc(1'b1, 16'd5, 1'b0, 1'b0);
        cyc(1'b1, 16'hfff6, 1'b0, 1'b0);
        cyc(1'b1, 16'hffec, 1'b0, 1'b0);
        n_checks++;
        if (bus.triggered !== 1'b0) begin
            n_fail++;
            $display("FAIL signed_no_false_hit: triggered=%b, expected 0", bus.triggered);
        end
        cyc(1'b1, 16'hfffb, 1'b0, 1'b0);
        n_checks++;
        if (bus.triggered !== 1'b1 || bus.trig_addr !== 8'd4) begin
            n_fail++;
            $display("FAIL signed_trigger: triggered=%b trig_addr=%0d, expected 1 4", bus.triggered, bus.trig_addr);
        end
    endtask

    task automatic test_arm_abort();
        int n;
        do_arm(8'd4, 16'd0, 1'b0);
        cyc(1'b1, 16'hfffd, 1'b0, 1'b0);
        cyc(1'b1, 16'hfffe, 1'b0, 1'b0);
        cyc(1'b1, 16'hffff, 1'b0, 1'b0);
        cyc(1'b1, 16'hffff, 1'b0, 1'b0);
        cyc(1'b1, 16'd5, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 16'd20, 1'b0, 1'b0);
        n_checks++;
        if (bus.triggered !== 1'b1 || bus.trig_addr !== 8'd4 || bus.state_dbg !== POST) begin
            n_fail++;
            $display("FAIL abort_first: triggered=%b trig_addr=%0d state=%0d, expected 1 4 POST",
                     bus.triggered, bus.trig_addr, bus.state_dbg);
        end
        cyc(1'b0, 16'h0000, 1'b0, 1'b0);
        clear_log();
        cyc(1'b1, 16'hfff9, 1'b1, 1'b0);
        n_checks++;
        if (bus.triggered !== 1'b0 || bus.busy !== 1'b1 || bus.buf_we !== 1'b1 ||
            bus.buf_waddr !== 8'd0 || bus.buf_wdata !== 16'hfff9) begin
            n_fail++;
            $display("FAIL abort_rearm: triggered=%b busy=%b we=%b waddr=%0d wdata=%0h, expected 0 1 1 0 fff9",
                     bus.triggered, bus.busy, bus.buf_we, bus.buf_waddr, bus.buf_wdata);
        end
        cyc(1'b1, 16'hfffa, 1'b0, 1'b0);
        cyc(1'b1, 16'hfffb, 1'b0, 1'b0);
        cyc(1'b1, 16'hfffc, 1'b0, 1'b0);
        cyc(1'b1, 16'd3, 1'b0, 1'b0);
        n_checks++;
        if (bus.triggered !== 1'b1 || bus.trig_addr !== 8'd4) begin
            n_fail++;
            $display("FAIL abort_retrigger: triggered=%b trig_addr=%0d, expected 1 4", bus.triggered, bus.trig_addr);
        end
        n = 0;
        while (bus.done !== 1'b1 && n < 300) begin
            cyc(1'b1, 16'd9, 1'b0, 1'b0);
            n++;
        end
        cyc(1'b0, 16'h0000, 1'b0, 1'b0);
        n_checks++;
        if (bus.done !== 1'b1 || n != 251 || wr_addr_q.size() != 256) begin
            n_fail++;
            $display("FAIL abort_complete: done=%b post_more=%0d writes=%0d, expected 1 251 256",
                     bus.done, n, wr_addr_q.size());
        end
    endtask

    task automatic test_rst_mid_pre();
        do_arm(8'd10, 16'd0, 1'b0);
        cyc(1'b1, 16'd1, 1'b0, 1'b0);
        cyc(1'b1, 16'd2, 1'b0, 1'b0);
        cyc(1'b1, 16'd3, 1'b0, 1'b0);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0);
        clear_log();
        bus.sample_valid = 1'b1;
        bus.sample_data  = 16'd4;
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.state_dbg !== IDLE || bus.busy !== 1'b0 || bus.buf_we !== 1'b0 ||
            bus.buf_waddr !== 8'd0 || bus.buf_wdata !== 16'd0 || bus.done !== 1'b0 ||
            bus.triggered !== 1'b0 || bus.trig_addr !== 8'd0) begin
            n_fail++;
            $display("FAIL rst_mid_pre: state=%0d busy=%b we=%b waddr=%0d wdata=%0h done=%b trig=%b, expected IDLE all zero",
                     bus.state_dbg, bus.busy, bus.buf_we, bus.buf_waddr, bus.buf_wdata, bus.done, bus.triggered);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) cyc(1'b1, 16'(40 + i), 1'b0, 1'b0);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0);
        n_checks++;
        if (wr_addr_q.size() != 0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_no_writes: writes=%0d busy=%b, expected 0 0", wr_addr_q.size(), bus.busy);
        end
        do_arm(8'd10, 16'd0, 1'b0);
        cyc(1'b1, 16'd77, 1'b0, 1'b0);
        n_checks++;
        if (bus.buf_we !== 1'b1 || bus.buf_waddr !== 8'd0 || bus.buf_wdata !== 16'd77) begin
            n_fail++;
            $display("FAIL rst_rearm_write: we=%b waddr=%0d wdata=%0h, expected 1 0 4d",
                     bus.buf_we, bus.buf_waddr, bus.buf_wdata);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_checks         = 0;
        n_fail           = 0;
        rst              = 1'b1;
        bus.arm          = 1'b0;
        bus.force_trig   = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample_data  = '0;
        bus.trig_level   = '0;
        bus.trig_falling = 1'b0;
        bus.pre_count    = '0;
        test_reset();
        test_ramp_rising();
        test_force_pre0();
        test_wrap();
        test_stall();
        test_edge_modes();
        test_arm_abort();
        test_rst_mid_pre();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
